// File: rtl/logic_unit_pkg.sv
// Shared opcode encoding and op-field width for the pipelined logic unit.
package logic_unit_pkg;
  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_NOTA = 3'd6,
    OP_PASS = 3'd7
  } op_e;
endpackage

// File: rtl/logic_unit_pipe_if.sv
// Operand-side and result-side valid/ready bundle of the logic unit.
interface logic_unit_pipe_if
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [OP_W-1:0]  op;
  logic             acc;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] r;
  logic             zero;
  logic             ones;
  logic             parity;

  modport master (
    output in_valid, a, b, op, acc, out_ready,
    input  in_ready, out_valid, r, zero, ones, parity
  );

  modport slave (
    input  in_valid, a, b, op, acc, out_ready,
    output in_ready, out_valid, r, zero, ones, parity
  );
endinterface

// File: rtl/logic_op_core.sv
// Combinational bitwise operation plus result flags.
module logic_op_core
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a_eff,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ones,
  output logic             parity
);
  always_comb begin
    result = '0;
    case (op)
      OP_AND:  result = a_eff & b;
      OP_OR:   result = a_eff | b;
      OP_XOR:  result = a_eff ^ b;
      OP_NAND: result = ~(a_eff & b);
      OP_NOR:  result = ~(a_eff | b);
      OP_XNOR: result = ~(a_eff ^ b);
      OP_NOTA: result = ~a_eff;
      default: result = a_eff;
    endcase
    zero   = (result == '0);
    ones   = &result;
    parity = ^result;
  end
endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage elastic logic unit: operand capture, then compute/result with
// an accumulate path fed by the most recently issued result.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic               clk,
  input logic               rst,
  logic_unit_pipe_if.slave  bus
);
  logic             vld_p0, vld_p1;
  logic [WIDTH-1:0] a_p0, b_p0;
  logic [OP_W-1:0]  op_p0;
  logic             acc_p0;
  logic [WIDTH-1:0] r_p1, last_result;
  logic             zero_p1, ones_p1, parity_p1;

  logic             adv0, adv1, accept;
  logic [WIDTH-1:0] a_eff, res;
  logic             res_zero, res_ones, res_parity;

  assign adv1         = !vld_p1 || bus.out_ready;
  assign adv0         = vld_p0 && adv1;
  assign bus.in_ready = !vld_p0 || adv1;
  assign accept       = bus.in_valid && bus.in_ready;

  // last_result is updated in issue order, so the chained operand is always
  // the previous operation's result even if that result is still stalled.
  assign a_eff = acc_p0 ? last_result : a_p0;

  logic_op_core #(.WIDTH(WIDTH)) u_core (
    .op     (op_p0),
    .a_eff  (a_eff),
    .b      (b_p0),
    .result (res),
    .zero   (res_zero),
    .ones   (res_ones),
    .parity (res_parity)
  );

  // Stage 0: operand capture
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      a_p0   <= '0;
      b_p0   <= '0;
      op_p0  <= '0;
      acc_p0 <= 1'b0;
    end else begin
      if (accept) begin
        vld_p0 <= 1'b1;
        a_p0   <= bus.a;
        b_p0   <= bus.b;
        op_p0  <= bus.op;
        acc_p0 <= bus.acc;
      end else if (adv0) begin
        vld_p0 <= 1'b0;
      end
    end
  end

  // Stage 1: result and flags
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1      <= 1'b0;
      r_p1        <= '0;
      zero_p1     <= 1'b0;
      ones_p1     <= 1'b0;
      parity_p1   <= 1'b0;
      last_result <= '0;
    end else begin
      if (adv1) vld_p1 <= vld_p0;
      if (adv0) begin
        r_p1        <= res;
        zero_p1     <= res_zero;
        ones_p1     <= res_ones;
        parity_p1   <= res_parity;
        last_result <= res;
      end
    end
  end

  assign bus.out_valid = vld_p1;
  assign bus.r         = r_p1;
  assign bus.zero      = zero_p1;
  assign bus.ones      = ones_p1;
  assign bus.parity    = parity_p1;
endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed bench for logic_unit_pipe: streamed vector table plus stall and reset sequences.
module tb_logic_unit_pipe;
  logic clk;
  logic rst;

  logic_unit_pipe_if #(.WIDTH(16)) bus ();

  logic_unit_pipe #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic        acc;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] r;
    logic        z;
    logic        o;
    logic        p;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic acc,
                       input logic [15:0] a, input logic [15:0] b);
    bus.in_valid = v;
    bus.op       = op;
    bus.acc      = acc;
    bus.a        = a;
    bus.b        = b;
  endtask

  task automatic chk_out(input string nm, input logic [15:0] r, input logic z,
                         input logic o, input logic p);
    chk({nm, " out_valid"}, bus.out_valid, 1'b1);
    chk({nm, " r"}, bus.r, r);
    chk({nm, " zero"}, bus.zero, z);
    chk({nm, " ones"}, bus.ones, o);
    chk({nm, " parity"}, bus.parity, p);
  endtask

  initial begin
    vecs[0]  = '{3'd0, 1'b0, 16'h00F8, 16'h0147, 16'h0040, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{3'd1, 1'b0, 16'h00F8, 16'h0147, 16'h01FF, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{3'd2, 1'b0, 16'h00F8, 16'h0147, 16'h01BF, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{3'd3, 1'b0, 16'h00F8, 16'h0147, 16'hFFBF, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{3'd4, 1'b0, 16'h00F8, 16'h0147, 16'hFE00, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{3'd5, 1'b0, 16'h00F8, 16'h0147, 16'hFE40, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{3'd6, 1'b0, 16'h00F8, 16'h0147, 16'hFF07, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{3'd7, 1'b0, 16'h00F8, 16'h0147, 16'h00F8, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{3'd0, 1'b0, 16'hF0F0, 16'h0F0F, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{3'd5, 1'b0, 16'h1234, 16'h1234, 16'hFFFF, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{3'd1, 1'b0, 16'h000F, 16'h0000, 16'h000F, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{3'd2, 1'b1, 16'hDEAD, 16'h00FF, 16'h00F0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{3'd6, 1'b1, 16'hBEEF, 16'h5555, 16'hFF0F, 1'b0, 1'b0, 1'b0};

    rst = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b0, 3'd0, 1'b0, 16'h0, 16'h0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("reset out_valid", bus.out_valid, 1'b0);
    chk("reset r", bus.r, 16'h0);
    chk("reset zero", bus.zero, 1'b0);
    chk("reset ones", bus.ones, 1'b0);
    chk("reset parity", bus.parity, 1'b0);
    chk("reset in_ready", bus.in_ready, 1'b1);

    // Back-to-back stream: result i must appear right after edge i+1, no bubbles.
    for (int c = 0; c <= NV; c++) begin
      if (c < NV) drive(1'b1, vecs[c].op, vecs[c].acc, vecs[c].a, vecs[c].b);
      else        drive(1'b0, 3'd0, 1'b0, 16'h0, 16'h0);
      #1;
      if (c < NV) chk($sformatf("stream in_ready %0d", c), bus.in_ready, 1'b1);
      tick();
      if (c == 0) chk("first latency out_valid", bus.out_valid, 1'b0);
      else chk_out($sformatf("vec%0d", c - 1), vecs[c-1].r, vecs[c-1].z, vecs[c-1].o, vecs[c-1].p);
    end
    tick();
    chk("stream drained out_valid", bus.out_valid, 1'b0);

    // Backpressure: two accepted, third blocked, outputs frozen, then drain.
    bus.out_ready = 1'b0;
    drive(1'b1, 3'd7, 1'b0, 16'h1111, 16'h0);
    #1;
    chk("bp in_ready op1", bus.in_ready, 1'b1);
    tick();
    drive(1'b1, 3'd7, 1'b0, 16'h2222, 16'h0);
    #1;
    chk("bp in_ready op2", bus.in_ready, 1'b1);
    tick();
    drive(1'b1, 3'd7, 1'b0, 16'h3333, 16'h0);
    #1;
    chk("bp in_ready op3 blocked", bus.in_ready, 1'b0);
    chk_out("bp head", 16'h1111, 1'b0, 1'b0, 1'b0);
    tick();
    chk("bp still blocked", bus.in_ready, 1'b0);
    chk_out("bp held", 16'h1111, 1'b0, 1'b0, 1'b0);
    bus.out_ready = 1'b1;
    #1;
    chk("bp in_ready on release", bus.in_ready, 1'b1);
    tick();
    drive(1'b0, 3'd0, 1'b0, 16'h0, 16'h0);
    chk_out("bp drain2", 16'h2222, 1'b0, 1'b0, 1'b0);
    tick();
    chk_out("bp drain3", 16'h3333, 1'b0, 1'b0, 1'b0);
    tick();
    chk("bp empty", bus.out_valid, 1'b0);

    // Reset with two operations in flight discards them and clears last_result.
    drive(1'b1, 3'd7, 1'b0, 16'h00F0, 16'h0);
    tick();
    drive(1'b1, 3'd7, 1'b0, 16'h0A0A, 16'h0);
    tick();
    chk("pre-reset out_valid", bus.out_valid, 1'b1);
    drive(1'b0, 3'd0, 1'b0, 16'h0, 16'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("midrst out_valid", bus.out_valid, 1'b0);
    chk("midrst in_ready", bus.in_ready, 1'b1);
    chk("midrst r", bus.r, 16'h0);
    tick();
    chk("midrst nothing emitted", bus.out_valid, 1'b0);
    drive(1'b1, 3'd1, 1'b1, 16'hFFFF, 16'h0003);
    tick();
    drive(1'b0, 3'd0, 1'b0, 16'h0, 16'h0);
    tick();
    chk_out("acc after reset", 16'h0003, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
